// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce, building a nibble-packed display number
// handed off over valid/ready. Optional beep output when KEY_BEEP_EN is defined.
module keypad_entry #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int BEEP_CYCLES    = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  row_out,
    input  logic [3:0]  col_in,
    output logic [31:0] number,
    output logic [3:0]  digit_cnt,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        enter_valid,
`ifdef KEY_BEEP_EN
    output logic        beep,
`endif
    input  logic        enter_ready
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEB, HELD} state_t;

    logic [3:0]       col_meta_reg, col_sync_reg;
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       row_reg;
    logic             hit_reg, multi_reg;
    logic [3:0]       code_reg;
    state_t           state_reg, state_next;
    logic [3:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             key_fire;
    logic             key_valid_reg;
    logic [3:0]       key_code_reg;
    logic [31:0]      number_reg;
    logic [3:0]       digit_cnt_reg;
    logic             enter_valid_reg;

    logic       sample_tick, scan_end;
    logic [3:0] col_act;
    logic [1:0] col_idx;
    logic       row_single, row_multi;
    logic [3:0] row_code;
    logic       scan_single, scan_multi, scan_none;
    logic [3:0] scan_code;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_reg <= 4'hF;
            col_sync_reg <= 4'hF;
            div_reg      <= '0;
            row_reg      <= 2'd0;
        end else begin
            col_meta_reg <= col_in;
            col_sync_reg <= col_meta_reg;
            if (sample_tick) begin
                div_reg <= '0;
                row_reg <= row_reg + 2'd1;
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
        end
    end

    assign row_out     = ~(4'b0001 << row_reg);
    assign sample_tick = (div_reg == DIV_LAST);
    assign scan_end    = sample_tick && (row_reg == 2'd3);
    assign col_act     = ~col_sync_reg;

    always_comb begin
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (col_act[c]) col_idx = 2'(c);
        end
    end

    assign row_single = (col_act != 4'd0) && ((col_act & (col_act - 4'd1)) == 4'd0);
    assign row_multi  = (col_act != 4'd0) && !row_single;
    assign row_code   = key_lookup(row_reg, col_idx);

    // Current row's sample folded into the rows already seen this scan.
    assign scan_multi  = multi_reg || row_multi || (hit_reg && row_single);
    assign scan_single = !scan_multi && (hit_reg || row_single);
    assign scan_none   = !scan_multi && !scan_single;
    assign scan_code   = hit_reg ? code_reg : row_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_reg   <= 1'b0;
            multi_reg <= 1'b0;
            code_reg  <= 4'd0;
        end else if (scan_end) begin
            hit_reg   <= 1'b0;
            multi_reg <= 1'b0;
            code_reg  <= 4'd0;
        end else if (sample_tick) begin
            hit_reg   <= hit_reg || row_single;
            multi_reg <= scan_multi;
            code_reg  <= scan_code;
        end
    end

    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        key_fire   = 1'b0;
        if (scan_end) begin
            case (state_reg)
                IDLE: if (scan_single) begin
                    state_next = DEB;
                    cand_next  = scan_code;
                    cnt_next   = CNT_W'(1);
                end
                DEB: if (scan_single && (scan_code == cand_reg)) begin
                    if (cnt_inc == DEB_DONE) begin
                        key_fire   = 1'b1;
                        state_next = HELD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    state_next = IDLE;
                end
                HELD: if (scan_none) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == DEB_DONE) state_next = IDLE;
                end else begin
                    cnt_next = '0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cand_reg      <= 4'd0;
            cnt_reg       <= '0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'd0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            key_valid_reg <= key_fire;
            if (key_fire) key_code_reg <= cand_reg;
        end
    end

    // A pending entry freezes the buffer; keys seen meanwhile are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_reg      <= 32'hFFFF_FFFF;
            digit_cnt_reg   <= 4'd0;
            enter_valid_reg <= 1'b0;
        end else if (enter_valid_reg) begin
            if (enter_ready) begin
                enter_valid_reg <= 1'b0;
                number_reg      <= 32'hFFFF_FFFF;
                digit_cnt_reg   <= 4'd0;
            end
        end else if (key_valid_reg) begin
            case (key_code_reg)
                4'hA: if (digit_cnt_reg != 4'd0) begin
                    number_reg    <= {4'hF, number_reg[31:4]};
                    digit_cnt_reg <= digit_cnt_reg - 4'd1;
                end
                4'hB: begin
                    number_reg    <= 32'hFFFF_FFFF;
                    digit_cnt_reg <= 4'd0;
                end
                4'hF: if (digit_cnt_reg != 4'd0) enter_valid_reg <= 1'b1;
                4'hC, 4'hD, 4'hE: ;
                default: if (digit_cnt_reg < 4'd8) begin
                    number_reg    <= {number_reg[27:0], key_code_reg};
                    digit_cnt_reg <= digit_cnt_reg + 4'd1;
                end
            endcase
        end
    end

`ifdef KEY_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);
    logic [BEEP_W-1:0] beep_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt_reg <= '0;
        end else if (key_valid_reg) begin
            beep_cnt_reg <= BEEP_W'(BEEP_CYCLES);
        end else if (beep_cnt_reg != '0) begin
            beep_cnt_reg <= beep_cnt_reg - BEEP_W'(1);
        end
    end

    assign beep = (beep_cnt_reg != '0);
`endif

    assign number      = number_reg;
    assign digit_cnt   = digit_cnt_reg;
    assign key_valid   = key_valid_reg;
    assign key_code    = key_code_reg;
    assign enter_valid = enter_valid_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model drives col_in, a scoreboard holds the expected
// key code and buffer state for every press, popped when key_valid fires.
module tb_keypad_entry;
    localparam int SCAN_DIV = 4;
    localparam int SCAN     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [31:0] number;
    logic [3:0]  digit_cnt;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        enter_valid;
    logic        enter_ready = 1'b0;
    logic [15:0] press_mask = 16'd0;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] num;
        logic [3:0]  cnt;
        logic        ev;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_num = 32'hFFFF_FFFF;
    logic [3:0]  m_cnt = 4'd0;
    logic        m_ev  = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(2), .BEEP_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .row_out(row_out), .col_in(col_in),
        .number(number), .digit_cnt(digit_cnt), .key_valid(key_valid),
        .key_code(key_code), .enter_valid(enter_valid), .enter_ready(enter_ready)
    );

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (press_mask[r*4+c]) col_in[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int key_pos(input logic [3:0] code);
        case (code)
            4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'hA: return 3;
            4'h4: return 4;   4'h5: return 5;   4'h6: return 6;   4'hB: return 7;
            4'h7: return 8;   4'h8: return 9;   4'h9: return 10;  4'hC: return 11;
            4'hE: return 12;  4'h0: return 13;  4'hF: return 14;  default: return 15;
        endcase
    endfunction

    task automatic press_key(input logic [3:0] code);
        exp_t e;
        if (!m_ev) begin
            case (code)
                4'hA: if (m_cnt != 0) begin m_num = {4'hF, m_num[31:4]}; m_cnt--; end
                4'hB: begin m_num = 32'hFFFF_FFFF; m_cnt = 0; end
                4'hF: if (m_cnt != 0) m_ev = 1'b1;
                4'hC, 4'hD, 4'hE: ;
                default: if (m_cnt < 8) begin m_num = {m_num[27:0], code}; m_cnt++; end
            endcase
        end
        e.code = code; e.num = m_num; e.cnt = m_cnt; e.ev = m_ev;
        sb.push_back(e);
        @(negedge clk);
        press_mask = 16'd1 << key_pos(code);
        repeat (4 * SCAN) @(negedge clk);
        press_mask = 16'd0;
        repeat (3 * SCAN) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard consumer: key_code on the pulse, buffer state one clock later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_key", 32'(key_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("key_code", 32'(key_code), 32'(e.code));
                    @(negedge clk);
                    check("key_pulse", 32'(key_valid), 32'd0);
                    check("number", number, e.num);
                    check("digit_cnt", 32'(digit_cnt), 32'(e.cnt));
                    check("enter_valid", 32'(enter_valid), 32'(e.ev));
                    $display("key %h number=%h digit_cnt=%0d enter_valid=%0d",
                             e.code, number, digit_cnt, enter_valid);
                end
            end
        end
    end

    initial begin
        logic [3:0] exp_row;
        repeat (3) @(negedge clk);
        check("rst_row", 32'(row_out), 32'hE);
        check("rst_number", number, 32'hFFFF_FFFF);
        check("rst_cnt", 32'(digit_cnt), 32'd0);
        check("rst_kv", 32'(key_valid), 32'd0);
        check("rst_ev", 32'(enter_valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_row = ~(4'b0001 << (((i + 1) / SCAN_DIV) % 4));
            check("row_scan", 32'(row_out), 32'(exp_row));
        end
        repeat (4 * SCAN) @(negedge clk);
        check("idle_number", number, 32'hFFFF_FFFF);

        press_key(4'h1);
        check("one_number", number, 32'hFFFF_FFF1);
        check("one_cnt", 32'(digit_cnt), 32'd1);

        press_key(4'h2); press_key(4'h3); press_key(4'h4); press_key(4'hA);
        check("bs_number", number, 32'hFFFF_F123);
        check("bs_cnt", 32'(digit_cnt), 32'd3);
        press_key(4'hB);
        check("clr_number", number, 32'hFFFF_FFFF);
        check("clr_cnt", 32'(digit_cnt), 32'd0);

        enter_ready = 1'b1;
        for (int d = 1; d <= 9; d++) press_key(4'(d));
        enter_ready = 1'b0;
        check("full_number", number, 32'h1234_5678);
        check("full_cnt", 32'(digit_cnt), 32'd8);
        check("full_ev", 32'(enter_valid), 32'd0);
        press_key(4'hB);

        press_key(4'h5); press_key(4'h6); press_key(4'hF);
        check("ent_ev", 32'(enter_valid), 32'd1);
        check("ent_number", number, 32'hFFFF_FF56);
        press_key(4'h7);
        check("frozen_number", number, 32'hFFFF_FF56);
        check("frozen_ev", 32'(enter_valid), 32'd1);
        enter_ready = 1'b1;
        @(negedge clk);
        enter_ready = 1'b0;
        m_num = 32'hFFFF_FFFF; m_cnt = 4'd0; m_ev = 1'b0;
        check("acc_ev", 32'(enter_valid), 32'd0);
        check("acc_number", number, 32'hFFFF_FFFF);
        check("acc_cnt", 32'(digit_cnt), 32'd0);

        press_key(4'h3);
        for (int i = 0; i < 4; i++) begin
            press_mask = 16'd1 << key_pos(4'h5);
            repeat (SCAN) @(negedge clk);
            press_mask = 16'd0;
            repeat (SCAN) @(negedge clk);
        end
        press_mask = 16'h0003;
        repeat (4 * SCAN) @(negedge clk);
        press_mask = 16'd0;
        repeat (3 * SCAN) @(negedge clk);
        check("bounce_sb", 32'(sb.size()), 32'd0);
        check("bounce_number", number, 32'hFFFF_FFF3);

        for (int i = 0; i < SCAN && row_out != 4'b0111; i++) @(negedge clk);
        check("align_row3", 32'(row_out), 32'h7);
        press_mask = 16'd1 << key_pos(4'h8);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        press_mask = 16'd0;
        m_num = 32'hFFFF_FFFF; m_cnt = 4'd0; m_ev = 1'b0;
        check("mid_rst_row", 32'(row_out), 32'hE);
        check("mid_rst_number", number, 32'hFFFF_FFFF);
        check("mid_rst_cnt", 32'(digit_cnt), 32'd0);
        check("mid_rst_kv", 32'(key_valid), 32'd0);
        check("mid_rst_code", 32'(key_code), 32'd0);
        check("mid_rst_ev", 32'(enter_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * SCAN) @(negedge clk);
        check("post_rst_number", number, 32'hFFFF_FFFF);

        press_key(4'h9);
        check("final_number", number, 32'hFFFF_FFF9);
        check("final_cnt", 32'(digit_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
